// File: rtl/clk_reset_sequencer.sv
// Power-up / reset sequencer. Waits for the oscillator to settle and the PLL
// to hold lock, then releases the memory, video and CPU reset domains in that
// order and generates the CPU clock enable. It also handles CPU-only soft
// resets, and it re-sequences from WAIT_LOCK whenever lock is lost.
//
// Input handshake: there is no valid/ready pair on this block.
// - soft_reset_req is a level that is sampled on every clk edge.
// - pll_lock is an asynchronous level and is synchronized internally.
// - Every output is a registered level. ce_cpu is a single-cycle strobe.
module clk_reset_sequencer #(
  parameter int STARTUP_CYCLES = 1024,
  parameter int LOCK_FILTER    = 16,
  parameter int STAGE_GAP      = 64,
  parameter int CPU_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       rst_mem_n,
  output logic       rst_vid_n,
  output logic       rst_cpu_n,
  output logic       ce_cpu,
  output logic       ready,
  output logic [2:0] state
);

  // The counter is sized from the largest timing parameter, plus one spare bit.
  localparam int MAX_AB = (STARTUP_CYCLES > LOCK_FILTER) ? STARTUP_CYCLES : LOCK_FILTER;
  localparam int MAX_CD = (STAGE_GAP > CPU_DIV) ? STAGE_GAP : CPU_DIV;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;
  localparam int DW     = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  // Terminal count values, one per timed state.
  localparam logic [CW-1:0] C_HOLD_END = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] C_LOCK_END = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] C_GAP_END  = CW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] C_DIV_END  = DW'(CPU_DIV - 1);

  // State encodings. These are exported unchanged on the debug 'state' port.
  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_REL_MEM   = 3'd2;
  localparam logic [2:0] S_REL_VID   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_SOFT      = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_div;
  logic          r_lock_meta;
  logic          r_lock_s;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_div_nxt;
  logic          w_ce_nxt;
  logic          w_mem_nxt;
  logic          w_vid_nxt;
  logic          w_cpu_nxt;
  logic          w_ready_nxt;

  // Two-flop synchronizer that brings the asynchronous pll_lock into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state and counter logic. Lock loss takes priority over everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == C_HOLD_END) begin
          w_state_nxt = S_WAIT_LOCK;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          if (r_cnt == C_LOCK_END) begin
            w_state_nxt = S_REL_MEM;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_REL_MEM: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_cnt == C_GAP_END) begin
          w_state_nxt = S_REL_VID;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_REL_VID: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_cnt == C_GAP_END) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (soft_reset_req) begin
          w_state_nxt = S_SOFT;
        end
      end
      S_SOFT: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (soft_reset_req) begin
          // A repeated request restarts the pulse, so cnt stays cleared.
          w_state_nxt = S_SOFT;
        end else if (r_cnt == C_GAP_END) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  // CPU clock-enable divider. It only runs while the FSM stays in RUN.
  always_comb begin
    w_div_nxt = '0;
    w_ce_nxt  = 1'b0;
    if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
      if (r_div == C_DIV_END) begin
        w_div_nxt = '0;
        w_ce_nxt  = 1'b1;
      end else begin
        w_div_nxt = r_div + DW'(1);
      end
    end
  end

  // Reset and ready levels are decoded from the next state, so the registered outputs change on the same edge as the state.
  always_comb begin
    w_mem_nxt   = 1'b0;
    w_vid_nxt   = 1'b0;
    w_cpu_nxt   = 1'b0;
    w_ready_nxt = 1'b0;
    case (w_state_nxt)
      S_REL_MEM: begin
        w_mem_nxt = 1'b1;
      end
      S_REL_VID: begin
        w_mem_nxt = 1'b1;
        w_vid_nxt = 1'b1;
      end
      S_RUN: begin
        w_mem_nxt   = 1'b1;
        w_vid_nxt   = 1'b1;
        w_cpu_nxt   = 1'b1;
        w_ready_nxt = 1'b1;
      end
      S_SOFT: begin
        w_mem_nxt = 1'b1;
        w_vid_nxt = 1'b1;
      end
      default: begin
        w_mem_nxt = 1'b0;
      end
    endcase
  end

  // State, counter, divider and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_div     <= '0;
      rst_mem_n <= 1'b0;
      rst_vid_n <= 1'b0;
      rst_cpu_n <= 1'b0;
      ce_cpu    <= 1'b0;
      ready     <= 1'b0;
      state     <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      rst_mem_n <= w_mem_nxt;
      rst_vid_n <= w_vid_nxt;
      rst_cpu_n <= w_cpu_nxt;
      ce_cpu    <= w_ce_nxt;
      ready     <= w_ready_nxt;
      state     <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Directed bench for clk_reset_sequencer with small timing parameters.
// Output vector = {rst_mem_n, rst_vid_n, rst_cpu_n, ready, ce_cpu, state[2:0]}.
module tb_clk_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_reset_req;
  logic       rst_mem_n;
  logic       rst_vid_n;
  logic       rst_cpu_n;
  logic       ce_cpu;
  logic       ready;
  logic [2:0] state;
  logic [7:0] outs;

  int checks;
  int errors;
  int edge_n;

  clk_reset_sequencer #(
    .STARTUP_CYCLES(8),
    .LOCK_FILTER   (4),
    .STAGE_GAP     (4),
    .CPU_DIV       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .soft_reset_req(soft_reset_req),
    .rst_mem_n     (rst_mem_n),
    .rst_vid_n     (rst_vid_n),
    .rst_cpu_n     (rst_cpu_n),
    .ce_cpu        (ce_cpu),
    .ready         (ready),
    .state         (state)
  );

  assign outs = {rst_mem_n, rst_vid_n, rst_cpu_n, ready, ce_cpu, state};

  // Clock block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int k);
    while (edge_n < k) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, outs, exp, edge_n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    rst_n = 1'b1;
    pll_lock = 1'b1;
    soft_reset_req = 1'b0;

    // Reset is asserted; all outputs must read 0.
    #2 rst_n = 1'b0;
    #1 chk("reset_all_zero", 8'b0000_0_000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;

    // Cold start.
    go_to(7);  chk("hold_e7",      8'b0000_0_000);
    go_to(8);  chk("wait_lock_e8", 8'b0000_0_001);
    go_to(11); chk("wait_e11",     8'b0000_0_001);
    go_to(12); chk("rel_mem_e12",  8'b1000_0_010);
    go_to(15); chk("rel_mem_e15",  8'b1000_0_010);
    go_to(16); chk("rel_vid_e16",  8'b1100_0_011);
    go_to(19); chk("rel_vid_e19",  8'b1100_0_011);
    go_to(20); chk("run_e20",      8'b1111_0_100);
    go_to(23); chk("run_noce_e23", 8'b1111_0_100);
    go_to(24); chk("ce_e24",       8'b1111_1_100);
    go_to(25); chk("ce_off_e25",   8'b1111_0_100);
    go_to(28); chk("ce_e28",       8'b1111_1_100);
    go_to(32); chk("ce_e32",       8'b1111_1_100);

    // Single soft reset request, sampled at edge 34.
    go_to(33); soft_reset_req = 1'b1;
    go_to(34); soft_reset_req = 1'b0;
    chk("soft_e34", 8'b1100_0_101);
    go_to(37); chk("soft_e37", 8'b1100_0_101);
    go_to(38); chk("soft_back_run_e38", 8'b1111_0_100);
    go_to(41); chk("soft_noce_e41", 8'b1111_0_100);
    go_to(42); chk("soft_ce_e42",   8'b1111_1_100);

    // Soft reset at edge 43, extended by a second request at edge 45.
    soft_reset_req = 1'b1;
    go_to(43); soft_reset_req = 1'b0;
    chk("soft2_e43", 8'b1100_0_101);
    go_to(44); soft_reset_req = 1'b1;
    go_to(45); soft_reset_req = 1'b0;
    go_to(47); chk("soft_ext_e47", 8'b1100_0_101);
    go_to(48); chk("soft_ext_e48", 8'b1100_0_101);
    go_to(49); chk("soft_ext_run_e49", 8'b1111_0_100);

    // Lock loss in RUN; the drop is seen by the FSM at edge 53.
    go_to(50); pll_lock = 1'b0;
    go_to(52); chk("lockloss_still_run_e52", 8'b1111_0_100);
    go_to(53); chk("lockloss_e53", 8'b0000_0_001);
    go_to(55); pll_lock = 1'b1;
    go_to(60); chk("relock_wait_e60", 8'b0000_0_001);
    go_to(61); chk("relock_mem_e61",  8'b1000_0_010);
    go_to(65); chk("relock_vid_e65",  8'b1100_0_011);
    go_to(69); chk("relock_run_e69",  8'b1111_0_100);

    // Lock loss and a soft request on the same edge (73); lock loss wins.
    go_to(70); pll_lock = 1'b0;
    go_to(72); soft_reset_req = 1'b1;
    go_to(73); soft_reset_req = 1'b0;
    chk("lock_beats_soft_e73", 8'b0000_0_001);
    go_to(74); pll_lock = 1'b1;
    go_to(79); chk("relock2_wait_e79", 8'b0000_0_001);
    go_to(80); chk("relock2_mem_e80",  8'b1000_0_010);
    go_to(84); chk("relock2_vid_e84",  8'b1100_0_011);

    // Reset asserted in REL_VID; outputs must clear with no clock edge.
    go_to(85);
    rst_n = 1'b0;
    #1 chk("async_reset_mid", 8'b0000_0_000);
    repeat (2) @(negedge clk);
    chk("async_reset_held", 8'b0000_0_000);
    rst_n = 1'b1;
    edge_n = 0;

    // Replay from HOLD, with a one-cycle lock glitch during WAIT_LOCK.
    go_to(8); chk("replay_wait_e8", 8'b0000_0_001);
    go_to(9); pll_lock = 1'b0;
    go_to(10); pll_lock = 1'b1;
    go_to(12); chk("glitch_no_rel_e12", 8'b0000_0_001);
    go_to(15); chk("glitch_wait_e15",   8'b0000_0_001);
    go_to(16); chk("glitch_rel_e16",    8'b1000_0_010);
    go_to(20); chk("glitch_vid_e20",    8'b1100_0_011);
    go_to(24); chk("glitch_run_e24",    8'b1111_0_100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_reset_sequencer.md
# clk_reset_sequencer

Power-up and reset sequencer clocked by the on-chip oscillator. It holds off the design until the oscillator has settled and the PLL has locked stably. It then releases the memory, video and CPU reset domains in a fixed order and generates the Z80 clock enable. It also handles CPU-only soft resets and full re-sequencing on PLL lock loss. It sits at the top level between the oscillator/PLL primitives and every other block.

## Interface
Parameters:
- STARTUP_CYCLES, 1024: oscillator settle time in clk cycles (≥2).
- LOCK_FILTER, 16: consecutive cycles synchronized pll_lock must be high (≥1).
- STAGE_GAP, 64: cycles between successive domain releases; also the soft-reset pulse length (≥1).
- CPU_DIV, 4: ce_cpu period in clk cycles (≥2).

Ports:
- clk  in  1  oscillator clock (internal OSC, FREQ_DIV 16).
- rst_n  in  1  reset; asynchronous, active-low.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- soft_reset_req  in  1  synchronous request for a CPU-only reset.
- rst_mem_n  out  1  DRAM controller reset, active-low.
- rst_vid_n  out  1  video reset, active-low.
- rst_cpu_n  out  1  CPU reset, active-low.
- ce_cpu  out  1  one-cycle CPU clock enable.
- ready  out  1  system running.
- state  out  3  current state encoding, for debug.

## Operation
- pll_lock passes through a 2-FF synchronizer (lock_s). Both flops reset to 0, giving 2 cycles of latency.
- A single counter, cnt, is cleared on every state change. States and encodings:
  - HOLD(0): cnt increments. At cnt==STARTUP_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK(1): if lock_s=1, cnt increments; else cnt=0. At cnt==LOCK_FILTER-1 with lock_s=1, go to REL_MEM.
  - REL_MEM(2): rst_mem_n=1. At cnt==STAGE_GAP-1, go to REL_VID.
  - REL_VID(3): rst_mem_n=1, rst_vid_n=1. At cnt==STAGE_GAP-1, go to RUN.
  - RUN(4): all resets high, ready=1, ce_cpu active. soft_reset_req=1 sends the FSM to SOFT.
  - SOFT(5): rst_mem_n=1, rst_vid_n=1, rst_cpu_n=0, ready=0, ce_cpu=0. At cnt==STAGE_GAP-1, go to RUN. soft_reset_req=1 while in SOFT clears cnt, restarting the pulse.
- Lock loss: lock_s=0 in REL_MEM, REL_VID, RUN or SOFT sends the FSM to WAIT_LOCK. All resets and ready go low. Lock loss has priority over soft_reset_req and over cnt terminal conditions.
- Encodings 6 and 7 are unused and go to HOLD.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state register. There are no combinational glitches on the reset outputs.
- ce_cpu uses a divider, div, of width $clog2(CPU_DIV):
  - div is held at 0 outside RUN.
  - In RUN, div counts 0..CPU_DIV-1 and wraps.
  - ce_cpu is registered, high for the one cycle following the edge on which div wraps to 0.
- Counter width is $clog2 of the largest of the parameters plus 1. Counters never overflow because every state clears cnt on its terminal value.

## Timing
- rst_n low: immediately and asynchronously, state=HOLD, cnt=0, div=0, synchronizer=0. All outputs are 0: rst_mem_n, rst_vid_n, rst_cpu_n, ce_cpu, ready and state.
- Assertion mid-sequence has the same effect; the sequence restarts from HOLD.
- Edge numbering: edge k is the k-th rising clk edge after rst_n deasserts.
- Nominal cold-start release points (pll_lock high, lock_s valid before HOLD ends):
  - rst_mem_n rises after edge STARTUP_CYCLES+LOCK_FILTER.
  - rst_vid_n rises STAGE_GAP edges later.
  - rst_cpu_n and ready rise a further STAGE_GAP edges later.
- Lock loss: 2-cycle synchronizer latency, then one edge to drop the resets.
- Soft reset: rst_cpu_n falls on the edge sampling the request and stays low for STAGE_GAP cycles.
- First ce_cpu after (re)entering RUN comes CPU_DIV edges after entry.

## Test plan
Parameters for all scenarios: STARTUP_CYCLES=8, LOCK_FILTER=4, STAGE_GAP=4, CPU_DIV=4.
- Cold start, pll_lock tied high -> state=1 after edge 8, rst_mem_n=1 after edge 12, rst_vid_n=1 after edge 16, rst_cpu_n=ready=1 after edge 20, ce_cpu high after edges 24, 28, 32.
- pll_lock glitches low for 1 cycle during WAIT_LOCK -> filter restarts; rst_mem_n rise is delayed by the glitch position plus 4 cycles.
- pll_lock drops in RUN -> 3 edges later all resets=0, ready=0, state=1; after lock returns, memory, video and CPU are released again in order, 4 cycles apart.
- soft_reset_req pulse in RUN -> rst_cpu_n=0 and ce_cpu=0 for 4 cycles while rst_mem_n and rst_vid_n stay 1; ce_cpu resumes 4 edges after returning to RUN. A second request during SOFT extends the low time.
- rst_n asserted in REL_VID -> all outputs 0 with no clk edge required; sequence replays from HOLD.
- Lock loss and soft_reset_req on the same edge in RUN -> WAIT_LOCK wins; state=1 and all resets low.
